// File: rtl/dpram_burst_arbiter.sv
`default_nettype none
// ============================================================================
// Module  : dpram_burst_arbiter
// Purpose : Round-robin burst arbiter sharing one DPRAM port between two
//           requesters; sequences per-beat address/strobe/data and read valid.
// Revision: 1.0 - initial release
// ============================================================================
module dpram_burst_arbiter #(
  parameter int DATA_WIDTH    = 8,
  parameter int ADDR_WIDTH    = 6,
  parameter int MAX_BURST_LEN = 4,
  localparam int LEN_W        = (MAX_BURST_LEN > 1) ? $clog2(MAX_BURST_LEN) : 1
) (
  input  logic                  clk,
  input  logic                  rst,
  // requester 0
  input  logic                  req_valid_0,
  output logic                  req_ready_0,
  input  logic                  req_we_0,
  input  logic [ADDR_WIDTH-1:0] req_addr_0,
  input  logic [LEN_W-1:0]      req_len_0,
  input  logic [DATA_WIDTH-1:0] wdata_0,
  output logic                  wdata_take_0,
  output logic [DATA_WIDTH-1:0] rdata_0,
  output logic                  rdata_valid_0,
  // requester 1
  input  logic                  req_valid_1,
  output logic                  req_ready_1,
  input  logic                  req_we_1,
  input  logic [ADDR_WIDTH-1:0] req_addr_1,
  input  logic [LEN_W-1:0]      req_len_1,
  input  logic [DATA_WIDTH-1:0] wdata_1,
  output logic                  wdata_take_1,
  output logic [DATA_WIDTH-1:0] rdata_1,
  output logic                  rdata_valid_1,
  // RAM port
  output logic                  ram_we,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout,
  // status
  output logic                  busy,
  output logic                  grant
);

  typedef enum logic [0:0] {
    S_IDLE  = 1'b0,
    S_BURST = 1'b1
  } state_t;

  state_t                  r_state;
  state_t                  w_state_nxt;

  logic                    r_we;
  logic                    r_owner;
  logic                    r_prio;
  logic                    r_rd_pend;
  logic                    r_rd_owner;
  logic [ADDR_WIDTH-1:0]   r_base;
  logic [LEN_W-1:0]        r_len;
  logic [LEN_W-1:0]        r_beat;

  logic                    w_sel;
  logic                    w_any_valid;
  logic                    w_accept;
  logic                    w_ready_0;
  logic                    w_ready_1;
  logic                    w_busy;
  logic                    w_last;
  logic [ADDR_WIDTH-1:0]   w_addr;

  assign w_any_valid = req_valid_0 | req_valid_1;
  assign w_busy      = (r_state == S_BURST);
  assign w_last      = (r_beat == r_len);
  assign w_addr      = r_base + ADDR_WIDTH'(r_beat);

  // A lone requester always wins; under contention r_prio names the one not granted last.
  always_comb begin
    w_sel = r_prio;
    if (req_valid_0 && !req_valid_1) begin
      w_sel = 1'b0;
    end else if (req_valid_1 && !req_valid_0) begin
      w_sel = 1'b1;
    end
  end

  // Next-state and handshake decode. Ready is held low while rst is high so a
  // request cannot be handshaked on a cycle whose state update is discarded.
  always_comb begin
    w_state_nxt = r_state;
    w_accept    = 1'b0;
    w_ready_0   = 1'b0;
    w_ready_1   = 1'b0;
    case (r_state)
      S_IDLE: begin
        if (!rst && w_any_valid) begin
          w_accept    = 1'b1;
          w_ready_0   = ~w_sel;
          w_ready_1   = w_sel;
          w_state_nxt = S_BURST;
        end
      end
      S_BURST: begin
        if (w_last) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_we       <= 1'b0;
      r_owner    <= 1'b0;
      r_prio     <= 1'b0;
      r_base     <= '0;
      r_len      <= '0;
      r_beat     <= '0;
      r_rd_pend  <= 1'b0;
      r_rd_owner <= 1'b0;
    end else begin
      // Registered RAM read: data for this beat returns on the next cycle.
      r_rd_pend  <= w_busy & ~r_we;
      r_rd_owner <= r_owner;
      if (w_accept) begin
        r_we    <= w_sel ? req_we_1   : req_we_0;
        r_base  <= w_sel ? req_addr_1 : req_addr_0;
        r_len   <= w_sel ? req_len_1  : req_len_0;
        r_owner <= w_sel;
        r_beat  <= '0;
      end else if (w_busy) begin
        r_beat <= r_beat + LEN_W'(1);
        if (w_last) begin
          r_prio <= ~r_owner;
        end
      end
    end
  end

  assign req_ready_0   = w_ready_0;
  assign req_ready_1   = w_ready_1;

  assign ram_we        = w_busy & r_we;
  assign ram_addr      = w_addr;
  assign ram_din       = r_owner ? wdata_1 : wdata_0;

  assign wdata_take_0  = ram_we & ~r_owner;
  assign wdata_take_1  = ram_we &  r_owner;

  assign rdata_0       = ram_dout;
  assign rdata_1       = ram_dout;
  assign rdata_valid_0 = r_rd_pend & ~r_rd_owner;
  assign rdata_valid_1 = r_rd_pend &  r_rd_owner;

  assign busy          = w_busy;
  assign grant         = r_owner;

endmodule
`default_nettype wire
